ws_sa_ctrl: RTL and testbench



---
 rtl/ws_sa_ctrl.sv | 116 +++++++++++
 tb/tb_ws_sa_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ws_sa_ctrl.sv
// Job sequencer for the weight-stationary systolic PE array: loads weights, streams a_vec, tracks c_vec validity.
// Define WS_SA_CTRL_PERF_EN to add the perf_cycles / perf_bubbles counters.
module ws_sa_ctrl #(
   parameter int SIZE = 8,
   parameter int ROW  = 8,
   parameter int COL  = 8,
   parameter int LAT  = 8,
   parameter int CNTW = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [CNTW-1:0]           n_vec,
   input  logic [COL*SIZE-1:0]       w_row,
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic [ROW*SIZE-1:0]       a_in,
   input  logic                      a_valid,
   output logic                      a_ready,
   output logic [ROW*COL*SIZE-1:0]   b_vec,
   output logic [ROW*SIZE-1:0]       a_vec,
   output logic                      c_valid,
   output logic                      busy,
   output logic                      done
`ifdef WS_SA_CTRL_PERF_EN
   ,
   output logic [31:0]               perf_cycles,
   output logic [31:0]               perf_bubbles
`endif
);

   localparam int RCW  = $clog2(ROW + 1);
   localparam int ROWB = COL * SIZE;
   localparam logic [RCW-1:0] LAST_ROW = RCW'(ROW - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]      state;
   logic [RCW-1:0]  row_cnt;
   logic [CNTW-1:0] vec_left;
   logic [LAT-1:0]  vld_sr;
   logic            beat_p0;

   assign w_ready = (state == S_LOAD_W);
   assign a_ready = (state == S_STREAM);
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign beat_p0 = a_ready & a_valid;

   // p0 -> p1: a_vec register and valid shift register advance together every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         row_cnt  <= '0;
         vec_left <= '0;
         vld_sr   <= '0;
         c_valid  <= 1'b0;
         b_vec    <= '0;
         a_vec    <= '0;
      end else begin
         vld_sr  <= (vld_sr << 1) | LAT'(beat_p0);
         c_valid <= vld_sr[LAT-1];
         a_vec   <= beat_p0 ? a_in : '0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  vec_left <= n_vec;
                  row_cnt  <= '0;
                  state    <= S_LOAD_W;
               end
            end
            S_LOAD_W: begin
               if (w_valid) begin
                  // row 1 sits in the MSBs of b_vec
                  for (int r = 0; r < ROW; r++) begin
                     if (row_cnt == RCW'(r)) b_vec[(ROW-1-r)*ROWB +: ROWB] <= w_row;
                  end
                  row_cnt <= row_cnt + RCW'(1);
                  if (row_cnt == LAST_ROW) state <= (vec_left != '0) ? S_STREAM : S_DONE;
               end
            end
            S_STREAM: begin
               if (a_valid) begin
                  if (vec_left != '0) vec_left <= vec_left - CNTW'(1);
                  if (vec_left <= CNTW'(1)) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((vld_sr == '0) && !c_valid) state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef WS_SA_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cycles  <= '0;
         perf_bubbles <= '0;
      end else if ((state == S_IDLE) && start) begin
         perf_cycles  <= '0;
         perf_bubbles <= '0;
      end else if (state != S_IDLE) begin
         perf_cycles <= perf_cycles + 32'd1;
         if ((state == S_STREAM) && !a_valid) perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ws_sa_ctrl.sv
// Directed, table-driven bench for ws_sa_ctrl: job table plus hand sequences for reset-abort.
module tb_ws_sa_ctrl;

   localparam int SIZE = 8;
   localparam int ROW  = 8;
   localparam int COL  = 8;
   localparam int LAT  = 8;
   localparam int CNTW = 16;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic [CNTW-1:0]         n_vec;
   logic [COL*SIZE-1:0]     w_row;
   logic                    w_valid;
   logic                    w_ready;
   logic [ROW*SIZE-1:0]     a_in;
   logic                    a_valid;
   logic                    a_ready;
   logic [ROW*COL*SIZE-1:0] b_vec;
   logic [ROW*SIZE-1:0]     a_vec;
   logic                    c_valid;
   logic                    busy;
   logic                    done;
`ifdef WS_SA_CTRL_PERF_EN
   logic [31:0]             perf_cycles;
   logic [31:0]             perf_bubbles;
`endif

   ws_sa_ctrl #(.SIZE(SIZE), .ROW(ROW), .COL(COL), .LAT(LAT), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .start(start), .n_vec(n_vec),
      .w_row(w_row), .w_valid(w_valid), .w_ready(w_ready),
      .a_in(a_in), .a_valid(a_valid), .a_ready(a_ready),
      .b_vec(b_vec), .a_vec(a_vec), .c_valid(c_valid), .busy(busy), .done(done)
`ifdef WS_SA_CTRL_PERF_EN
      , .perf_cycles(perf_cycles), .perf_bubbles(perf_bubbles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          n;
      int          gap;
      int          base;
      int          spur;
      int          busy;
      int          cvn;
      int          bub;
      logic [63:0] mask;
   } job_t;

   job_t        tab [6];
   int          nchk = 0;
   int          nerr = 0;
   int          cyc = 0;
   int          busy_cnt, done_cnt, cv_cnt, first_upd;
   logic [63:0] cv_mask;

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (c_valid) begin
         cv_cnt++;
         if (first_upd >= 0 && cyc >= first_upd && cyc - first_upd < 64) cv_mask[cyc-first_upd] = 1'b1;
      end
   endtask

   function automatic logic [63:0] pat(input int k);
      return 64'h0102030405060708 + 64'(k) * 64'h1010101010101010;
   endfunction

   function automatic logic [511:0] exp_w(input int base);
      logic [511:0] e;
      logic [7:0]   bt;
      e = '0;
      for (int r = 0; r < ROW; r++) begin
         bt = 8'(base + r);
         e[(ROW-1-r)*64 +: 64] = {COL{bt}};
      end
      return e;
   endfunction

   task automatic load_w(input int base);
      logic [7:0] bt;
      for (int r = 0; r < ROW; r++) begin
         bt      = 8'(base + r);
         w_valid = 1'b1;
         w_row   = {COL{bt}};
         do_cycle();
      end
      w_valid = 1'b0;
   endtask

   task automatic run_job(input job_t j);
      int guard;
      busy_cnt = 0; done_cnt = 0; cv_cnt = 0; cv_mask = '0; first_upd = -1;
      n_vec = CNTW'(j.n);
      start = 1'b1;
      do_cycle();
      start = 1'b0;
      load_w(j.base);
      check("b_vec_load", 512'(b_vec), exp_w(j.base));
      for (int k = 0; k < j.n; k++) begin
         a_valid = 1'b1;
         a_in    = pat(k);
         if (j.spur != 0) begin
            start   = 1'b1;
            w_valid = 1'b1;
            w_row   = '1;
         end
         do_cycle();
         a_valid = 1'b0;
         check("a_vec_beat", 512'(a_vec), 512'(pat(k)));
         if (k == 0) begin
            first_upd = cyc;
            for (int g = 0; g < j.gap; g++) begin
               do_cycle();
               check("a_vec_gap", 512'(a_vec), 512'(0));
            end
         end
      end
      start   = 1'b0;
      w_valid = 1'b0;
      if (j.spur != 0) check("b_vec_hold", 512'(b_vec), exp_w(j.base));
      guard = 0;
      while (done_cnt == 0 && guard < 200) begin
         do_cycle();
         guard++;
      end
      do_cycle();
      check("idle_busy", 512'(busy), 512'(0));
      check("done_pulses", 512'(done_cnt), 512'(1));
      check("busy_cycles", 512'(busy_cnt), 512'(j.busy));
      check("c_valid_count", 512'(cv_cnt), 512'(j.cvn));
      check("c_valid_pattern", 512'(cv_mask), 512'(j.mask));
      check("b_vec_idle", 512'(b_vec), exp_w(j.base));
`ifdef WS_SA_CTRL_PERF_EN
      check("perf_cycles", 512'(perf_cycles), 512'(j.busy));
      check("perf_bubbles", 512'(perf_bubbles), 512'(j.bub));
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      tab[0] = '{n: 4, gap: 0, base: 8'h01, spur: 0, busy: 23, cvn: 4, bub: 0, mask: 64'h0F00};
      tab[1] = '{n: 3, gap: 2, base: 8'h11, spur: 0, busy: 24, cvn: 3, bub: 2, mask: 64'h1900};
      tab[2] = '{n: 0, gap: 0, base: 8'h21, spur: 0, busy: 9,  cvn: 0, bub: 0, mask: 64'h0000};
      tab[3] = '{n: 4, gap: 0, base: 8'h31, spur: 1, busy: 23, cvn: 4, bub: 0, mask: 64'h0F00};
      tab[4] = '{n: 2, gap: 0, base: 8'h41, spur: 0, busy: 21, cvn: 2, bub: 0, mask: 64'h0300};
      tab[5] = '{n: 5, gap: 1, base: 8'h51, spur: 0, busy: 25, cvn: 5, bub: 1, mask: 64'h3D00};

      reset = 1'b1; start = 1'b0; n_vec = '0; w_row = '0; w_valid = 1'b0;
      a_in = '0; a_valid = 1'b0;
      busy_cnt = 0; done_cnt = 0; cv_cnt = 0; cv_mask = '0; first_upd = -1;
      repeat (2) do_cycle();
      check("rst_b_vec", 512'(b_vec), 512'(0));
      check("rst_ctrl", 512'({a_vec, c_valid, w_ready, a_ready, busy, done}), 512'(0));
      reset = 1'b0;
      do_cycle();

      // consecutive jobs: each start lands in the IDLE cycle right after done
      for (int i = 0; i < 6; i++) run_job(tab[i]);

      // abort in the third DRAIN cycle
      busy_cnt = 0; done_cnt = 0; cv_cnt = 0; first_upd = -1;
      n_vec = 16'd2;
      start = 1'b1;
      do_cycle();
      start = 1'b0;
      load_w(8'h61);
      for (int k = 0; k < 2; k++) begin
         a_valid = 1'b1;
         a_in    = pat(k);
         do_cycle();
      end
      a_valid = 1'b0;
      check("drain_busy", 512'(busy), 512'(1));
      repeat (2) do_cycle();
      reset = 1'b1;
      do_cycle();
      reset = 1'b0;
      check("abort_b_vec", 512'(b_vec), 512'(0));
      check("abort_ctrl", 512'({a_vec, c_valid, w_ready, a_ready, busy, done}), 512'(0));
      done_cnt = 0; cv_cnt = 0;
      repeat (12) do_cycle();
      check("abort_no_done", 512'(done_cnt), 512'(0));
      check("abort_no_c_valid", 512'(cv_cnt), 512'(0));
      check("abort_idle", 512'(busy), 512'(0));

      run_job(tab[0]);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
